seq_stage_ctrl: RTL and testbench

Multi-cycle stage sequencer for the Y86-64 SEQ datapath. It owns the architectural PC and the status register, and issues one stage-enable per cycle in the order fetch, decode, execute, memory, write-back, PC-update. The memory stage stalls on a ready handshake with a bounded timeout. The block also keeps cycle and retired-instruction counters. It replaces free-running, clock-level stage evaluation with explicit per-stage sequencing, so that slow memories and error/halt termination are handled deterministically.

---
 rtl/seq_stage_ctrl_if.sv | 41 ++++
 rtl/seq_stage_ctrl.sv | 154 +++++++++++++++
 tb/tb_seq_stage_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_stage_ctrl_if.sv
// Bus bundle for the SEQ stage sequencer: fetch/memory status inputs,
// PC handshake, stage enables, status and performance counters.
interface seq_stage_ctrl_if #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) ();
  logic             start;
  logic [PC_W-1:0]  pc_init;
  logic             imem_error;
  logic             instr_valid;
  logic             hlt;
  logic             mem_ready;
  logic             dmem_error;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  pc;
  logic [2:0]       stage;
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             mem_en;
  logic             wb_en;
  logic             pcupd_en;
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  // Datapath / testbench side: drives the status inputs, observes the sequencer
  modport master (
    output start, pc_init, imem_error, instr_valid, hlt, mem_ready, dmem_error, next_pc,
    input  pc, stage, fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en, stat, halted,
    input  cycle_cnt, instr_cnt
  );

  // Sequencer side
  modport slave (
    input  start, pc_init, imem_error, instr_valid, hlt, mem_ready, dmem_error, next_pc,
    output pc, stage, fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en, stat, halted,
    output cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Y86-64 SEQ stage sequencer: walks FETCH..PCUPD one stage per cycle, owns the
// architectural PC and status, stalls MEMORY on mem_ready with a bounded timeout,
// and keeps saturating cycle / retired-instruction counters.
module seq_stage_ctrl #(
  parameter int unsigned PC_W         = 64,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  seq_stage_ctrl_if.slave     bus
);

  localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  // Encoding is the externally visible stage code
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StPcupd     = 3'd6,
    StHalt      = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State register: all architectural and bookkeeping flops, async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      stat_q      <= StatAok;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stat_q      <= stat_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state logic: stage sequencing, termination, PC and counter updates
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stat_d      = stat_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    wait_cnt_d  = '0;  // only MEMORY holds a nonzero wait count

    if (state_q != StIdle && state_q != StHalt) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
    end

    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          pc_d        = bus.pc_init;
          stat_d      = StatAok;
          cycle_cnt_d = '0;
          instr_cnt_d = '0;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        if (bus.imem_error) begin
          stat_d  = StatAdr;
          state_d = StHalt;
        end else if (!bus.instr_valid) begin
          stat_d  = StatIns;
          state_d = StHalt;
        end else if (bus.hlt) begin
          stat_d      = StatHlt;
          instr_cnt_d = sat_inc(instr_cnt_q);  // halt retires
          state_d     = StHalt;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: state_d = StMemory;
      StMemory: begin
        if (bus.mem_ready) begin
          if (bus.dmem_error) begin
            stat_d  = StatAdr;
            state_d = StHalt;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_cnt_q == WaitLast) begin
          stat_d  = StatAdr;
          state_d = StHalt;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StWriteback: state_d = StPcupd;
      StPcupd: begin
        pc_d        = bus.next_pc;
        instr_cnt_d = sat_inc(instr_cnt_q);
        state_d     = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs: enables and halted decode from the state register only
  always_comb begin
    bus.fetch_en  = 1'b0;
    bus.decode_en = 1'b0;
    bus.exec_en   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.wb_en     = 1'b0;
    bus.pcupd_en  = 1'b0;
    unique case (state_q)
      StFetch:     bus.fetch_en  = 1'b1;
      StDecode:    bus.decode_en = 1'b1;
      StExecute:   bus.exec_en   = 1'b1;
      StMemory:    bus.mem_en    = 1'b1;
      StWriteback: bus.wb_en     = 1'b1;
      StPcupd:     bus.pcupd_en  = 1'b1;
      default:     ;
    endcase
    bus.halted    = (state_q == StHalt);
    bus.stage     = state_q;
    bus.pc        = pc_q;
    bus.stat      = stat_q;
    bus.cycle_cnt = cycle_cnt_q;
    bus.instr_cnt = instr_cnt_q;
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Bench for seq_stage_ctrl: two instances (short memory timeout / 3-bit counters)
// share one directed stimulus; a behavioural model is checked every cycle.
module tb_seq_stage_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [63:0] pc_init = '0;
  logic imem_error = 1'b0;
  logic instr_valid = 1'b1;
  logic hlt = 1'b0;
  logic mem_ready = 1'b1;
  logic dmem_error = 1'b0;
  logic [63:0] next_pc = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_stage_ctrl_if #(.PC_W(64), .CNT_W(32)) ifa ();
  seq_stage_ctrl_if #(.PC_W(64), .CNT_W(3))  ifb ();

  assign ifa.start = start;       assign ifb.start = start;
  assign ifa.pc_init = pc_init;   assign ifb.pc_init = pc_init;
  assign ifa.imem_error = imem_error;   assign ifb.imem_error = imem_error;
  assign ifa.instr_valid = instr_valid; assign ifb.instr_valid = instr_valid;
  assign ifa.hlt = hlt;           assign ifb.hlt = hlt;
  assign ifa.mem_ready = mem_ready;     assign ifb.mem_ready = mem_ready;
  assign ifa.dmem_error = dmem_error;   assign ifb.dmem_error = dmem_error;
  assign ifa.next_pc = next_pc;   assign ifb.next_pc = next_pc;

  seq_stage_ctrl #(.PC_W(64), .CNT_W(32), .MEM_WAIT_MAX(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  seq_stage_ctrl #(.PC_W(64), .CNT_W(3), .MEM_WAIT_MAX(15)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  logic [5:0] en_a, en_b;
  assign en_a = {ifa.pcupd_en, ifa.wb_en, ifa.mem_en, ifa.exec_en, ifa.decode_en, ifa.fetch_en};
  assign en_b = {ifb.pcupd_en, ifb.wb_en, ifb.mem_en, ifb.exec_en, ifb.decode_en, ifb.fetch_en};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: [0] is dut_a (timeout 4, 32-bit counters), [1] is dut_b
  int          m_stage[2] = '{0, 0};
  logic [63:0] m_pc[2]    = '{64'd0, 64'd0};
  int          m_stat[2]  = '{1, 1};
  longint      m_cyc[2]   = '{0, 0};
  longint      m_ins[2]   = '{0, 0};
  int          m_wait[2]  = '{0, 0};
  int          m_wmax[2]  = '{4, 15};
  longint      m_cmax[2]  = '{64'hFFFF_FFFF, 7};
  int          ms;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          m_stage[k] = 0; m_pc[k] = 0; m_stat[k] = 1;
          m_cyc[k] = 0; m_ins[k] = 0; m_wait[k] = 0;
        end else if (clk) begin
          ms = m_stage[k];
          if (ms >= 1 && ms <= 6 && m_cyc[k] < m_cmax[k]) m_cyc[k]++;
          case (ms)
            0, 7: if (start) begin
              m_pc[k] = pc_init; m_stat[k] = 1; m_cyc[k] = 0; m_ins[k] = 0; m_stage[k] = 1;
            end
            1: begin
              if (imem_error) begin m_stat[k] = 3; m_stage[k] = 7; end
              else if (!instr_valid) begin m_stat[k] = 4; m_stage[k] = 7; end
              else if (hlt) begin
                m_stat[k] = 2; m_stage[k] = 7;
                if (m_ins[k] < m_cmax[k]) m_ins[k]++;
              end else m_stage[k] = 2;
            end
            2: m_stage[k] = 3;
            3: begin m_stage[k] = 4; m_wait[k] = 0; end
            4: begin
              if (mem_ready) begin
                if (dmem_error) begin m_stat[k] = 3; m_stage[k] = 7; end
                else m_stage[k] = 5;
              end else if (m_wait[k] == m_wmax[k] - 1) begin
                m_stat[k] = 3; m_stage[k] = 7;
              end else m_wait[k]++;
            end
            5: m_stage[k] = 6;
            6: begin
              m_pc[k] = next_pc; m_stage[k] = 1;
              if (m_ins[k] < m_cmax[k]) m_ins[k]++;
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic cmp_one(input int k, input logic [2:0] st, input logic [63:0] pc,
                         input logic [2:0] stat, input logic [5:0] en, input logic h,
                         input logic [63:0] cc, input logic [63:0] ic);
    string p;
    logic [5:0] en_exp;
    p = (k == 0) ? "a" : "b";
    en_exp = (m_stage[k] >= 1 && m_stage[k] <= 6) ? (6'd1 << (m_stage[k] - 1)) : 6'd0;
    chk({p, ".stage"}, 64'(st), 64'(m_stage[k]));
    chk({p, ".pc"}, pc, m_pc[k]);
    chk({p, ".stat"}, 64'(stat), 64'(m_stat[k]));
    chk({p, ".enables"}, 64'(en), 64'(en_exp));
    chk({p, ".halted"}, 64'(h), 64'(m_stage[k] == 7));
    chk({p, ".cycle_cnt"}, cc, 64'(m_cyc[k]));
    chk({p, ".instr_cnt"}, ic, 64'(m_ins[k]));
  endtask

  // Every-cycle compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      cmp_one(0, ifa.stage, ifa.pc, ifa.stat, en_a, ifa.halted, 64'(ifa.cycle_cnt),
              64'(ifa.instr_cnt));
      cmp_one(1, ifb.stage, ifb.pc, ifb.stat, en_b, ifb.halted, 64'(ifb.cycle_cnt),
              64'(ifb.instr_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [63:0] addr);
    pc_init = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset with start asserted: reset wins
    reset = 1'b1; start = 1'b1; pc_init = 64'h40;
    tick();
    chk("rst.pc", ifa.pc, 64'h0);
    chk("rst.stat", 64'(ifa.stat), 64'd1);
    chk("rst.stage", 64'(ifa.stage), 64'd0);
    chk("rst.cycle", 64'(ifa.cycle_cnt), 64'd0);
    chk("rst.instr", 64'(ifa.instr_cnt), 64'd0);
    chk("rst.en", 64'(en_a), 64'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("rel.stage", 64'(ifa.stage), 64'd0);

    // Single instruction, six stages
    next_pc = 64'h10A;
    restart(64'h100);
    for (int i = 0; i < 6; i++) begin
      chk("walk.en", 64'(en_a), 64'd1 << i);
      tick();
    end
    chk("i1.pc", ifa.pc, 64'h10A);
    chk("i1.instr", 64'(ifa.instr_cnt), 64'd1);
    chk("i1.cycle", 64'(ifa.cycle_cnt), 64'd6);
    chk("i1.fetch_en", 64'(ifa.fetch_en), 64'd1);

    // Second instruction: 3-bit cycle counter saturates
    next_pc = 64'h114;
    repeat (6) tick();
    chk("sat.cycle_b", 64'(ifb.cycle_cnt), 64'd7);
    chk("sat.instr_b", 64'(ifb.instr_cnt), 64'd2);
    chk("i2.cycle_a", 64'(ifa.cycle_cnt), 64'd12);

    // Halt in fetch
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    chk("hlt.stat", 64'(ifa.stat), 64'd2);
    chk("hlt.halted", 64'(ifa.halted), 64'd1);
    chk("hlt.instr", 64'(ifa.instr_cnt), 64'd3);
    chk("hlt.cycle", 64'(ifa.cycle_cnt), 64'd13);
    chk("sat.hold_b", 64'(ifb.cycle_cnt), 64'd7);
    repeat (3) tick();
    chk("hlt.frozen", 64'(ifa.cycle_cnt), 64'd13);

    // Illegal opcode
    restart(64'h200);
    instr_valid = 1'b0;
    tick();
    chk("ins.stat", 64'(ifa.stat), 64'd4);

    // imem_error outranks illegal opcode
    restart(64'h200);
    imem_error = 1'b1;
    tick();
    imem_error = 1'b0; instr_valid = 1'b1;
    chk("adr.stat", 64'(ifa.stat), 64'd3);

    // Restart from HALT at address 0
    restart(64'h0);
    chk("rs.stat", 64'(ifa.stat), 64'd1);
    chk("rs.cycle", 64'(ifa.cycle_cnt), 64'd0);
    chk("rs.instr", 64'(ifa.instr_cnt), 64'd0);
    chk("rs.stage", 64'(ifa.stage), 64'd1);

    // Two-cycle memory stall: 8 cycles total
    repeat (3) tick();
    chk("stall.stage", 64'(ifa.stage), 64'd4);
    mem_ready = 1'b0;
    repeat (2) tick();
    chk("stall.hold", 64'(ifa.stage), 64'd4);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("stall.cycle", 64'(ifa.cycle_cnt), 64'd8);
    chk("stall.pc", ifa.pc, 64'h114);

    // Timeout: a halts after 4 MEMORY cycles, b after 15
    repeat (3) tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    chk("to.pre", 64'(ifa.stage), 64'd4);
    tick();
    chk("to.stage", 64'(ifa.stage), 64'd7);
    chk("to.stat", 64'(ifa.stat), 64'd3);
    chk("to.b_wait", 64'(ifb.stage), 64'd4);
    repeat (14) tick();
    chk("to.b_stat", 64'(ifb.stat), 64'd3);
    chk("to.b_halt", 64'(ifb.halted), 64'd1);
    mem_ready = 1'b1;

    // Data address error
    restart(64'h300);
    repeat (3) tick();
    dmem_error = 1'b1;
    tick();
    dmem_error = 1'b0;
    chk("dmem.stat", 64'(ifa.stat), 64'd3);
    chk("dmem.stage", 64'(ifa.stage), 64'd7);

    // Async reset mid-EXECUTE, between edges
    restart(64'h300);
    repeat (2) tick();
    chk("ar.exec", 64'(ifa.stage), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar.stage", 64'(ifa.stage), 64'd0);
    chk("ar.pc", ifa.pc, 64'h0);
    start = 1'b1; pc_init = 64'h500;
    tick();
    chk("ar.start_ign", 64'(ifa.stage), 64'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("ar.idle", 64'(ifa.stage), 64'd0);

    // Clean instruction after reset
    restart(64'h400);
    repeat (6) tick();
    chk("post.pc", ifa.pc, 64'h114);
    chk("post.instr", 64'(ifa.instr_cnt), 64'd1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
